// File: rtl/cache_wb_pkg.sv
// Shared types and sizing helpers for the cache write-back buffer.
// Entries pair a word-aligned address with its 32-bit data word.
package cache_wb_pkg;

    localparam int WB_DEPTH_DEFAULT = 8;
    localparam int WB_ADDR_WIDTH    = 32;
    localparam int WB_DATA_WIDTH    = 32;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    // Pointers wrap modulo depth; the count needs one extra bit to represent "full".
    function automatic int wb_ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int wb_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int WB_PTR_W_DEFAULT = wb_ptr_width(WB_DEPTH_DEFAULT);
    localparam int WB_CNT_W_DEFAULT = wb_cnt_width(WB_DEPTH_DEFAULT);

endpackage

// File: rtl/cache_wb_forward_match.sv
// Youngest-first address matcher over the write-buffer entry array.
// Walks entries oldest to youngest so the last hit (closest to tail) wins.
module cache_wb_forward_match
    import cache_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT,
    parameter int PTR_W = wb_ptr_width(DEPTH),
    parameter int CNT_W = wb_cnt_width(DEPTH)
) (
    input  wb_entry_t [DEPTH-1:0]      i_entries,
    input  logic      [PTR_W-1:0]      i_head,
    input  logic      [CNT_W-1:0]      i_count,
    input  logic      [WB_ADDR_WIDTH-1:0] i_addr,
    output logic                       o_hit,
    output logic      [WB_DATA_WIDTH-1:0] o_data
);

    // NOTE: every variable written here gets a default first, otherwise paths
    // that skip an assignment infer a latch.
    always_comb begin
        logic [PTR_W-1:0] slot;
        slot   = i_head;
        o_hit  = 1'b0;
        o_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = i_head + PTR_W'(i);
            if ((CNT_W'(i) < i_count) && (i_entries[slot].addr == i_addr)) begin
                o_hit  = 1'b1;
                o_data = i_entries[slot].data;
            end
        end
    end

endmodule

// File: rtl/cache_writeback_buffer.sv
// Posted write buffer: absorbs one dirty word per cycle, drains in push order via req/ack.
// Define CACHE_WB_FORWARD_EN to build the youngest-entry forwarding lookup on rd_addr_i.
module cache_writeback_buffer
    import cache_wb_pkg::*;
#(
    parameter int DEPTH      = WB_DEPTH_DEFAULT,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           data_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  overflow_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  fwd_hit_o,
    output logic [31:0]           fwd_data_o
);

    localparam int PTR_W = wb_ptr_width(DEPTH);
    localparam int CNT_W = wb_cnt_width(DEPTH);

    wb_entry_t [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;

    logic      w_full;
    logic      w_empty;
    logic      w_push;
    logic      w_pop;
    wb_entry_t w_push_entry;
    wb_entry_t w_head_entry;
    logic      w_unused_bits;

    // Status comes from the registered count only, so wr_en_i/mem_ack_i never reach it.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = wr_en_i & ~w_full;
    assign w_pop   = ~w_empty & mem_ack_i;

    assign w_push_entry.addr = WB_ADDR_WIDTH'({addr_i[ADDR_WIDTH-1:2], 2'b00});
    assign w_push_entry.data = data_i;
    assign w_head_entry      = r_mem[r_head];

    // NOTE: state registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            if (w_push != w_pop) r_count <= w_push ? r_count + 1'b1 : r_count - 1'b1;
            if (wr_en_i & w_full) r_overflow <= 1'b1;
        end
    end

    // NOTE: entry storage is deliberately not reset; the count alone decides validity.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_tail] <= w_push_entry;
    end

    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign overflow_o  = r_overflow;
    assign mem_req_o   = ~w_empty;
    assign mem_addr_o  = w_empty ? '0 : ADDR_WIDTH'(w_head_entry.addr);
    assign mem_wdata_o = w_empty ? '0 : w_head_entry.data;

`ifdef CACHE_WB_FORWARD_EN
    cache_wb_forward_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_forward_match (
        .i_entries (r_mem),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_addr    (WB_ADDR_WIDTH'({rd_addr_i[ADDR_WIDTH-1:2], 2'b00})),
        .o_hit     (fwd_hit_o),
        .o_data    (fwd_data_o)
    );

    assign w_unused_bits = ^{addr_i[1:0], rd_addr_i[1:0]};
`else
    assign fwd_hit_o     = 1'b0;
    assign fwd_data_o    = '0;
    assign w_unused_bits = ^{addr_i[1:0], rd_addr_i};
`endif

endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Scoreboard bench for cache_writeback_buffer: queue-based reference model, directed + random stimulus.
// Forwarding expectations follow CACHE_WB_FORWARD_EN as defined for the build.
module tb_cache_writeback_buffer;
    import cache_wb_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          ack;
    logic [AW-1:0] rd_addr;
    logic          full_o, empty_o, overflow_o, mem_req_o, fwd_hit_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o, fwd_data_o;

    cache_writeback_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_en_i     (wr_en),
        .addr_i      (addr),
        .data_i      (data),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .overflow_o  (overflow_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (ack),
        .rd_addr_i   (rd_addr),
        .fwd_hit_o   (fwd_hit_o),
        .fwd_data_o  (fwd_data_o)
    );

    always #5 clk = ~clk;

    int        n_checks = 0;
    int        n_errors = 0;
    wb_entry_t m_q[$];
    wb_entry_t exp_q[$];
    bit        m_ovf = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock: apply the buffer's rules to the model at the edge, then release inputs.
    task automatic step();
        wb_entry_t e;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            bit do_push, do_pop;
            do_pop  = ack && (m_q.size() > 0);
            do_push = wr_en && (m_q.size() < DEPTH);
            if (wr_en && m_q.size() == DEPTH) m_ovf = 1'b1;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                e.addr = {addr[AW-1:2], 2'b00};
                e.data = data;
                m_q.push_back(e);
                exp_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic k);
        wr_en = w;
        addr  = a;
        data  = d;
        ack   = k;
        step();
    endtask

    // Monitor: compares status, head, forwarding and every transfer against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                bit            eh;
                logic [31:0]   ed;
                wb_entry_t     e;
                check("status", {60'd0, full_o, empty_o, mem_req_o, overflow_o},
                      {60'd0, m_q.size() == DEPTH, m_q.size() == 0, m_q.size() != 0, m_ovf});
                if (m_q.size() != 0)
                    check("head", {mem_addr_o, mem_wdata_o}, {m_q[0].addr, m_q[0].data});
                else
                    check("idle_bus", {mem_addr_o, mem_wdata_o}, 64'd0);
                eh = 1'b0;
                ed = '0;
`ifdef CACHE_WB_FORWARD_EN
                foreach (m_q[i])
                    if (m_q[i].addr == {rd_addr[AW-1:2], 2'b00}) begin
                        eh = 1'b1;
                        ed = m_q[i].data;
                    end
`endif
                check("fwd", {31'd0, fwd_hit_o, fwd_data_o}, {31'd0, eh, ed});
                if (mem_req_o && ack) begin
                    if (exp_q.size() == 0) begin
                        check("drain_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("drain", {mem_addr_o, mem_wdata_o}, {e.addr, e.data});
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; addr = '0; data = '0; ack = 1'b0; rd_addr = '0;
        step();
        step();
        rst = 1'b0;
        step();
        check("reset_state", {60'd0, full_o, empty_o, mem_req_o, overflow_o}, 64'b0100);

        // Single word held stable until acked.
        drive(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
        check("first_req", {31'd0, mem_req_o, mem_addr_o}, {31'd0, 1'b1, 32'h0000_1000});
        for (int i = 0; i < 5; i++) drive(1'b0, 0, 0, 1'b0);
        check("held_data", {32'd0, mem_wdata_o}, 64'hDEAD_BEEF);
        drive(1'b0, 0, 0, 1'b1);
        check("empty_after_ack", {63'd0, empty_o}, 64'd1);
        ack = 1'b0;

        // Fill, overflow, then back-to-back drain.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'h2000 + 32'(4 * i), 32'(i), 1'b0);
        check("full_after_8", {63'd0, full_o}, 64'd1);
        drive(1'b1, 32'h2020, 32'hBAD0_BAD0, 1'b0);
        check("overflow_set", {63'd0, overflow_o}, 64'd1);
        check("head_after_overflow", {32'd0, mem_wdata_o}, 64'd0);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 0, 0, 1'b1);
        check("drained", {63'd0, empty_o}, 64'd1);

        // Offset the pointers, fill, then pop alone followed by push+pop across the wrap.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h5000 + 32'(4 * i), 32'h50 + 32'(i), 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'h6000 + 32'(4 * i), 32'h60 + 32'(i), 1'b0);
        drive(1'b0, 0, 0, 1'b1);
        check("full_drops", {63'd0, full_o}, 64'd0);
        drive(1'b1, 32'h6100, 32'h61, 1'b1);
        check("count_7", {63'd0, full_o}, 64'd0);
        check("wrap_head", {32'd0, mem_wdata_o}, 64'h62);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 0, 0, 1'b1);

        // Forwarding lookups.
        drive(1'b1, 32'h3000, 32'h11, 1'b0);
        drive(1'b1, 32'h3000, 32'h22, 1'b0);
        rd_addr = 32'h3000;
        drive(1'b0, 0, 0, 1'b0);
`ifdef CACHE_WB_FORWARD_EN
        check("fwd_youngest", {31'd0, fwd_hit_o, fwd_data_o}, {31'd0, 1'b1, 32'h22});
`else
        check("fwd_disabled", {31'd0, fwd_hit_o, fwd_data_o}, 64'd0);
`endif
        rd_addr = 32'h3004;
        drive(1'b0, 0, 0, 1'b0);
        check("fwd_miss", {63'd0, fwd_hit_o}, 64'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 0, 0, 1'b1);

        // Reset with entries pending.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h7000 + 32'(4 * i), 32'h70 + 32'(i), 1'b0);
        check("pending_req", {63'd0, mem_req_o}, 64'd1);
        rst = 1'b1;
        drive(1'b0, 0, 0, 1'b0);
        rst = 1'b0;
        check("mid_reset", {61'd0, empty_o, mem_req_o, overflow_o}, 64'b100);
        drive(1'b1, 32'h7100, 32'h71, 1'b0);
        drive(1'b0, 0, 0, 1'b1);
        drive(1'b0, 0, 0, 1'b0);

        // Randomized traffic over a small address pool so forwarding hits often.
        for (int n = 0; n < 3000; n++) begin
            rd_addr = 32'h4000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            rst     = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 99) < 55,
                  32'h4000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
                  $urandom,
                  $urandom_range(0, 99) < 50);
            rst = 1'b0;
        end

        for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, 0, 0, 1'b1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
